// File: rtl/apb_gpio_slave_if.sv
// APB3 bus bundle between the APB master and the GPIO completer.
// The master drives the request side; the completer returns data, ready and error.
interface apb_gpio_slave_if #(
  parameter int ADDR_W = 3
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_slave.sv
// APB3 GPIO completer: IDLE/SETUP/ACCESS decode with programmable wait states,
// MODE/DIR/OUT/IN registers, 2-flop pad synchroniser, push-pull/open-drain pads.
// Build option GPIO_INT_EN: adds TRIG/IRQEN/POL/STAT (words 4..7) and the
// edge/level interrupt; without it those words read 0, ignore writes and irq=0.
module apb_gpio_slave #(
  parameter int ADDR_W      = 3,
  parameter int GPIO_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  apb_gpio_slave_if.slave   apb,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] A_MODE  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DIR   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_OUT   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_IN    = ADDR_W'(3);
`ifdef GPIO_INT_EN
  localparam logic [ADDR_W-1:0] A_TRIG  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_IRQEN = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_POL   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(7);
`endif

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        ready;
  logic        wr;
  logic [31:0] wmask32;
  logic [GPIO_W-1:0] wd, wm;
  logic [31:0] rdata;

  logic [GPIO_W-1:0] mode, dir, outr;
  logic [GPIO_W-1:0] sync1, sync2;

  // Protocol state and wait counter
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; PREADY is high only in the ACCESS cycle where the counter has expired
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    case (state)
      IDLE:   if (apb.PSEL && !apb.PENABLE) state_nxt = SETUP;
      SETUP: begin
        cnt_nxt   = 4'(WAIT_STATES);
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!apb.PSEL) begin
          state_nxt = IDLE;             // master gave up: drop the transfer
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          ready     = 1'b1;
          state_nxt = !apb.PENABLE ? SETUP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr      = ready && apb.PWRITE;
  assign wmask32 = {{8{apb.PSTRB[3]}}, {8{apb.PSTRB[2]}}, {8{apb.PSTRB[1]}}, {8{apb.PSTRB[0]}}};
  assign wd      = apb.PWDATA[GPIO_W-1:0];
  assign wm      = wmask32[GPIO_W-1:0];

  // Pad configuration registers, byte-lane merged on the completing edge
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      mode <= '0;
      dir  <= '0;
      outr <= '0;
    end else if (wr) begin
      case (apb.PADDR)
        A_MODE:  mode <= (mode & ~wm) | (wd & wm);
        A_DIR:   dir  <= (dir  & ~wm) | (wd & wm);
        A_OUT:   outr <= (outr & ~wm) | (wd & wm);
        default: ;
      endcase
    end
  end

  // Pad input synchroniser; sync2 is the value visible as IN
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_INT_EN
  logic [GPIO_W-1:0] trig, irqen, pol, stat, prev;
  logic [GPIO_W-1:0] hit, clr;

  // Interrupt configuration registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      trig  <= '0;
      irqen <= '0;
      pol   <= '0;
    end else if (wr) begin
      case (apb.PADDR)
        A_TRIG:  trig  <= (trig  & ~wm) | (wd & wm);
        A_IRQEN: irqen <= (irqen & ~wm) | (wd & wm);
        A_POL:   pol   <= (pol   & ~wm) | (wd & wm);
        default: ;
      endcase
    end
  end

  // Edge detect per bit, or level match re-asserting every cycle
  always_comb begin
    hit = '0;
    clr = '0;
    for (int i = 0; i < GPIO_W; i++) begin
      if (trig[i]) hit[i] = pol[i] ? (sync2[i] & ~prev[i]) : (~sync2[i] & prev[i]);
      else         hit[i] = (sync2[i] == pol[i]);
    end
    if (wr && apb.PADDR == A_STAT) clr = wd & wm;
  end

  // Status with set-over-clear priority, and the registered interrupt line
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      prev <= '0;
      stat <= '0;
      irq  <= 1'b0;
    end else begin
      prev <= sync2;
      stat <= (stat & ~clr) | hit;
      irq  <= |(stat & irqen);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux; unmapped or absent words read 0
  always_comb begin
    rdata = '0;
    case (apb.PADDR)
      A_MODE:  rdata = 32'(mode);
      A_DIR:   rdata = 32'(dir);
      A_OUT:   rdata = 32'(outr);
      A_IN:    rdata = 32'(sync2);
`ifdef GPIO_INT_EN
      A_TRIG:  rdata = 32'(trig);
      A_IRQEN: rdata = 32'(irqen);
      A_POL:   rdata = 32'(pol);
      A_STAT:  rdata = 32'(stat);
`endif
      default: rdata = '0;
    endcase
  end

  assign apb.PREADY  = ready;
  assign apb.PRDATA  = (ready && !apb.PWRITE) ? rdata : 32'h0;
  assign apb.PSLVERR = wr && (apb.PADDR == A_IN);

  // Open-drain bits never drive high: they only pull low where OUT=0
  assign gpio_out = outr & ~mode;
  assign gpio_oe  = dir & ~(mode & outr);

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave with WAIT_STATES=3. Each transfer queues
// its expected PRDATA/PSLVERR; a monitor pops and compares on every PREADY.
module tb_apb_gpio_slave;
  localparam int WS = 3;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out, gpio_oe;
  logic        irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_data[$];
  logic        q_err[$];
  string       q_tag[$];

  apb_gpio_slave_if #(.ADDR_W(3)) bus ();

  apb_gpio_slave #(.ADDR_W(3), .GPIO_W(32), .WAIT_STATES(WS)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .apb      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one queued expectation per completed transfer
  always @(negedge PCLK) begin
    if (bus.PREADY === 1'b1) begin
      if (q_data.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: got PREADY=1 expected no transfer");
      end else begin
        automatic logic [31:0] d = q_data.pop_front();
        automatic logic        e = q_err.pop_front();
        automatic string       t = q_tag.pop_front();
        chk({t, "_prdata"}, bus.PRDATA, d);
        chk({t, "_pslverr"}, {31'b0, bus.PSLVERR}, {31'b0, e});
      end
    end
  end

  // One APB transfer; optionally changes gpio_in at a chosen cycle inside ACCESS
  task automatic xfer(input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp_rd, input logic exp_err,
                      input string tag, input logic pad_en, input logic [31:0] pad_val);
    int k;
    q_data.push_back(wr ? 32'h0 : exp_rd);
    q_err.push_back(exp_err);
    q_tag.push_back(tag);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata; bus.PSTRB = strb;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    k = 0;
    while (bus.PREADY !== 1'b1 && k < 40) begin
      if (pad_en && k == WS - 1) gpio_in = pad_val;
      @(negedge PCLK);
      k++;
    end
    if (k >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no PREADY expected PREADY within 40 cycles", tag);
      void'(q_data.pop_front()); void'(q_err.pop_front()); void'(q_tag.pop_front());
    end else begin
      // ACCESS state is entered one cycle after PENABLE, then WS wait cycles
      chk({tag, "_latency"}, 32'(k), 32'(WS + 1));
    end
    @(posedge PCLK);
    #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic err, input string tag);
    xfer(1'b1, a, d, s, 32'h0, err, tag, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    xfer(1'b0, a, 32'h0, 4'h0, exp, 1'b0, tag, 1'b0, 32'h0);
  endtask

  initial begin
    PRESETn = 1'b0; gpio_in = '0;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_pready",  {31'b0, bus.PREADY}, 32'h0);
    chk("rst_prdata",  bus.PRDATA, 32'h0);
    chk("rst_pslverr", {31'b0, bus.PSLVERR}, 32'h0);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_oe",  gpio_oe, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    PRESETn = 1'b1;

    // Reset in the middle of an OUT write
    wr(3'd1, 32'hFFFFFFFF, 4'hF, 1'b0, "pre_dir");
    wr(3'd2, 32'hFFFFFFFF, 4'hF, 1'b0, "pre_out");
    chk("pre_gpio_out", gpio_out, 32'hFFFFFFFF);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 3'd2; bus.PWDATA = 32'h12345678; bus.PSTRB = 4'hF;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    chk("midrst_gpio_out", gpio_out, 32'h0);
    chk("midrst_gpio_oe",  gpio_oe, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    rd(3'd2, 32'h0, "midrst_out");
    rd(3'd1, 32'h0, "midrst_dir");

    // Push-pull output
    wr(3'd1, 32'hFFFFFFFF, 4'hF, 1'b0, "w_dir");
    wr(3'd2, 32'hA5A5A5A5, 4'hF, 1'b0, "w_out");
    wr(3'd0, 32'h00000000, 4'hF, 1'b0, "w_mode0");
    @(negedge PCLK);
    chk("pp_gpio_oe",  gpio_oe, 32'hFFFFFFFF);
    chk("pp_gpio_out", gpio_out, 32'hA5A5A5A5);
    rd(3'd2, 32'hA5A5A5A5, "r_out");

    // Byte-lane write, then open-drain
    wr(3'd2, 32'h12345678, 4'b0010, 1'b0, "w_out_strb");
    rd(3'd2, 32'hA5A556A5, "r_out_strb");
    wr(3'd0, 32'hFFFFFFFF, 4'hF, 1'b0, "w_mode1");
    @(negedge PCLK);
    chk("od_gpio_oe",  gpio_oe, 32'h5A5AA95A);
    chk("od_gpio_out", gpio_out, 32'h0);

    // IN is read-only; it tracks the synchronised pads
    gpio_in = 32'h000000F0;
    repeat (4) @(negedge PCLK);
    wr(3'd3, 32'hFFFFFFFF, 4'hF, 1'b1, "w_in_err");
    rd(3'd3, 32'h000000F0, "r_in");
    gpio_in = 32'h0;
    repeat (4) @(negedge PCLK);

`ifdef GPIO_INT_EN
    // Rising-edge interrupts; level-mode bits accumulated since reset are cleared
    wr(3'd4, 32'hFFFFFFFF, 4'hF, 1'b0, "w_trig");
    wr(3'd6, 32'hFFFFFFFF, 4'hF, 1'b0, "w_pol");
    wr(3'd7, 32'hFFFFFFFF, 4'hF, 1'b0, "w_stat_clrall");
    wr(3'd5, 32'h00000001, 4'hF, 1'b0, "w_irqen");
    rd(3'd7, 32'h0, "r_stat_clean");
    chk("irq_idle", {31'b0, irq}, 32'h0);
    gpio_in = 32'h5;
    repeat (5) @(negedge PCLK);
    rd(3'd7, 32'h5, "r_stat_5");
    chk("irq_set", {31'b0, irq}, 32'h1);
    wr(3'd7, 32'h1, 4'hF, 1'b0, "w_stat_w1c");
    repeat (2) @(negedge PCLK);
    rd(3'd7, 32'h4, "r_stat_4");
    chk("irq_clr", {31'b0, irq}, 32'h0);
    gpio_in = 32'h4;
    repeat (5) @(negedge PCLK);
    // New rising edge on bit0 lands on the same edge as the W1C commit
    xfer(1'b1, 3'd7, 32'h1, 4'hF, 32'h0, 1'b0, "w_stat_race", 1'b1, 32'h5);
    rd(3'd7, 32'h5, "r_stat_race");
    chk("irq_race", {31'b0, irq}, 32'h1);
`else
    // Interrupt words absent: reads 0, writes ignored without error, irq held low
    gpio_in = 32'hFFFF0000;
    repeat (6) @(negedge PCLK);
    chk("noint_irq_a", {31'b0, irq}, 32'h0);
    wr(3'd4, 32'hFFFFFFFF, 4'hF, 1'b0, "noint_w_trig");
    wr(3'd5, 32'hFFFFFFFF, 4'hF, 1'b0, "noint_w_irqen");
    wr(3'd7, 32'hFFFFFFFF, 4'hF, 1'b0, "noint_w_stat");
    rd(3'd4, 32'h0, "noint_r_trig");
    rd(3'd5, 32'h0, "noint_r_irqen");
    rd(3'd7, 32'h0, "noint_r_stat");
    rd(3'd3, 32'hFFFF0000, "noint_r_in");
    chk("noint_irq_b", {31'b0, irq}, 32'h0);
`endif

    repeat (3) @(negedge PCLK);
    chk("sb_drained", 32'(q_data.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
